// File: rtl/imem_arb.sv
// Fetch/debug arbiter for the single imem read port; fetch has priority, registered read data.
// Optional starvation guard enabled by defining IMEM_ARB_STARVE_EN.
module imem_arb #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DBG   = 2'd2
    } owner_t;

    owner_t            owner_reg, owner_next;
    logic [ADDR_W-1:0] last_addr_reg;
    logic [1:0]        gnt;            // bit 0 fetch, bit 1 debug
    logic              force_dbg;

`ifdef IMEM_ARB_STARVE_EN
    logic [3:0] starve_cnt_reg;

    // Counts cycles debug lost to fetch; any other outcome restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_reg <= 4'd0;
        end else if (dbg_req && gnt[0]) begin
            if (starve_cnt_reg != 4'(STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + 4'd1;
            end
        end else begin
            starve_cnt_reg <= 4'd0;
        end
    end

    assign force_dbg = (starve_cnt_reg == 4'(STARVE_MAX));
`else
    assign force_dbg = 1'b0;
`endif

    // Grants are held low during reset so nothing is captured while rst is high.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (dbg_req && (!if_req || force_dbg)) begin
                gnt[1] = 1'b1;
            end else if (if_req) begin
                gnt[0] = 1'b1;
            end
        end
    end

    assign if_gnt  = gnt[0];
    assign dbg_gnt = gnt[1];

    always_comb begin
        mem_addr = last_addr_reg;
        if (gnt[1]) begin
            mem_addr = dbg_addr;
        end else if (gnt[0]) begin
            mem_addr = if_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_addr_reg <= '0;
        end else if (|gnt) begin
            last_addr_reg <= mem_addr;
        end
    end

    always_comb begin
        owner_next = IDLE;
        if (gnt[0]) begin
            owner_next = FETCH;
        end else if (gnt[1]) begin
            owner_next = DBG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg <= IDLE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    // The rvalid pulses come straight from the state, so reset drops them at once.
    assign if_rvalid  = (owner_reg == FETCH);
    assign dbg_rvalid = (owner_reg == DBG);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] rdata_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg <= 32'h0;
                end else if (gnt[gi]) begin
                    rdata_reg <= mem_data;
                end
            end
        end
    endgenerate

    assign if_rdata  = g_port[0].rdata_reg;
    assign dbg_rdata = g_port[1].rdata_reg;

endmodule

// File: tb/tb_imem_arb.sv
// Scoreboard bench for imem_arb: stimulus pushes expected read data, a monitor pops it on rvalid.
module tb_imem_arb;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dbg_req = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;

    logic [31:0] mem_img [4];

    initial begin
        mem_img[0] = 32'h00000533;
        mem_img[1] = 32'h00250513;
        mem_img[2] = 32'h40a505b3;
        mem_img[3] = 32'hdeadbeef;
    end

    assign mem_data = (mem_addr < 10'd4) ? mem_img[mem_addr[1:0]] : 32'h0;

    imem_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    int                checks = 0;
    int                failures = 0;
    int                cyc = 0;
    logic [ADDR_W-1:0] exp_last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each cycle either the due read appears on its port, or both rvalids are low.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.port == 1'b0) begin
                chk("if_rvalid", {31'd0, if_rvalid}, 32'd1);
                chk("dbg_rvalid_quiet", {31'd0, dbg_rvalid}, 32'd0);
                chk("if_rdata", if_rdata, mon_e.data);
            end else begin
                chk("dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
                chk("if_rvalid_quiet", {31'd0, if_rvalid}, 32'd0);
                chk("dbg_rdata", dbg_rdata, mon_e.data);
            end
            $display("read port=%0d data=%h cycle=%0d", mon_e.port, mon_e.data, cyc);
        end else begin
            chk("if_rvalid_idle", {31'd0, if_rvalid}, 32'd0);
            chk("dbg_rvalid_idle", {31'd0, dbg_rvalid}, 32'd0);
        end
    end

    // win: 0 none, 1 fetch, 2 debug; xd is the word the winner must receive next cycle.
    task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                        input logic dr, input logic [ADDR_W-1:0] da,
                        input int win, input logic [31:0] xd);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
        @(negedge clk);
        chk("if_gnt", {31'd0, if_gnt}, {31'd0, (win == 1)});
        chk("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, (win == 2)});
        if (win == 1) exp_last = ia;
        else if (win == 2) exp_last = da;
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_last});
        if (win == 1) sb.push_back('{1'b0, xd, cyc + 1});
        else if (win == 2) sb.push_back('{1'b1, xd, cyc + 1});
        $display("txn if_req=%0d if_addr=%0d dbg_req=%0d dbg_addr=%0d win=%0d cycle=%0d",
                 ir, ia, dr, da, win, cyc);
    endtask

    initial begin
        int win;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        repeat (3) step(1'b0, 10'd0, 1'b0, 10'd0, 0, 32'h0);
        chk("if_rdata_reset", if_rdata, 32'h0);
        chk("dbg_rdata_reset", dbg_rdata, 32'h0);

        // Single fetch read at addr 1, then hold check
        step(1'b1, 10'd1, 1'b0, 10'd0, 1, 32'h00250513);
        step(1'b0, 10'd1, 1'b0, 10'd0, 0, 32'h0);
        step(1'b0, 10'd1, 1'b0, 10'd0, 0, 32'h0);
        chk("if_rdata_hold", if_rdata, 32'h00250513);

        // Single debug read at addr 2; fetch data untouched
        step(1'b0, 10'd0, 1'b1, 10'd2, 2, 32'h40a505b3);
        step(1'b0, 10'd0, 1'b0, 10'd2, 0, 32'h0);
        chk("dbg_rdata_hold", dbg_rdata, 32'h40a505b3);
        chk("if_rdata_undisturbed", if_rdata, 32'h00250513);

        // Both requesting continuously
        for (int k = 0; k < 10; k++) begin
`ifdef IMEM_ARB_STARVE_EN
            win = (k % 5 == 4) ? 2 : 1;
`else
            win = 1;
`endif
            step(1'b1, 10'd0, 1'b1, 10'd3, win, (win == 2) ? 32'hdeadbeef : 32'h00000533);
        end

        // Saturate the counter, drop dbg_req at saturation, then both again: fetch must win
        for (int k = 0; k < 4; k++) step(1'b1, 10'd0, 1'b1, 10'd3, 1, 32'h00000533);
        step(1'b1, 10'd0, 1'b0, 10'd3, 1, 32'h00000533);
        step(1'b1, 10'd0, 1'b1, 10'd3, 1, 32'h00000533);
        step(1'b0, 10'd0, 1'b0, 10'd0, 0, 32'h0);
        step(1'b0, 10'd0, 1'b0, 10'd0, 0, 32'h0);

        // Fetch granted at addr 0, reset pulsed before the capturing edge
        @(posedge clk);
        #1 if_req = 1'b1; if_addr = 10'd0;
        @(negedge clk);
        chk("rst_if_gnt_before", {31'd0, if_gnt}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_gnt_gated", {31'd0, if_gnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        exp_last = '0;

        // Reset while an rvalid pulse is showing drops it immediately
        @(posedge clk);
        #1 if_req = 1'b1; if_addr = 10'd2;
        @(posedge clk);
        #1 if_req = 1'b0;
        chk("pulse_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("pulse_if_rdata", if_rdata, 32'h40a505b3);
        #1 rst = 1'b1;
        #1 chk("pulse_dropped", {31'd0, if_rvalid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b0, 10'd0, 1'b0, 10'd0, 0, 32'h0);
        step(1'b0, 10'd0, 1'b0, 10'd0, 0, 32'h0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_arb.md
# imem_arb

Two-requester arbiter that shares the single instruction-memory read port between the pipeline fetch stage and the debug/loader readback port. It sits between the fetch stage, the debug unit and the `imem` block. It drives the word address into `imem`, registers the returned instruction word, and routes it back to the winning requester with one cycle of latency. Fetch has priority; a starvation guard can force a debug grant.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width (matches `imem` depth).
- `STARVE_MAX`, 4, consecutive debug-blocked cycles tolerated before a debug grant is forced (1..15).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch read request, level.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` is the word for the address granted the previous cycle.
- `if_rdata`  out  32  fetch read data, held between pulses.
- `dbg_req`  in  1  debug read request, level.
- `dbg_addr`  in  ADDR_W  debug word address.
- `dbg_gnt`  out  1  debug granted this cycle (combinational).
- `dbg_rvalid`  out  1  one-cycle pulse, debug data valid.
- `dbg_rdata`  out  32  debug read data, held between pulses.
- `mem_addr`  out  ADDR_W  address to `imem`.
- `mem_data`  in  32  combinational data from `imem`.

## Operation
- Grant decision is combinational from `if_req`, `dbg_req` and `force_dbg`. At most one grant is high per cycle.
  - Only one request high: that requester is granted.
  - Both high: fetch wins unless `force_dbg` is set.
  - Neither high: no grant.
- `mem_addr` carries the granted requester's address. With no grant it holds `last_addr`, the last granted address (a register).
- At each rising edge with a grant:
  - `mem_data` is captured into the winner's `*_rdata`.
  - The winner's `*_rvalid` is set for exactly one cycle.
  - `last_addr` is updated.
- Each `*_rdata` is held until that port's next `*_rvalid`. The other port's data is never disturbed.
- A requester holding `*_req` with an unchanged address is re-granted and re-read every cycle it wins. There is no request buffering; a losing requester must keep `*_req` asserted.
- Starvation counter `starve_cnt`, width 4:
  - Increments (saturating at `STARVE_MAX`) on each edge where `dbg_req` is high and fetch is granted.
  - Clears on any edge where debug is granted or `dbg_req` is low.
- `force_dbg = (starve_cnt == STARVE_MAX)`. While it is set and `dbg_req` is high, debug wins over fetch for one cycle, after which the counter clears.
- Grant-state register `owner` has three states: IDLE, FETCH, DBG. It records the previous cycle's grant and drives the `*_rvalid` pulses.
  - Any grant moves to FETCH or DBG.
  - No grant moves to IDLE.

## Timing
- Latency: address granted in cycle N; data and `*_rvalid` valid in cycle N+1.
- Throughput: one read per cycle, aggregated over both ports.
- Reset values:
  - `if_rvalid`, `dbg_rvalid` = 0.
  - `if_rdata`, `dbg_rdata` = 32'h0.
  - `last_addr` = 0, so `mem_addr` = 0 while idle.
  - `starve_cnt` = 0; `owner` = IDLE.
- Reset asserted mid-read:
  - A pending `*_rvalid` is dropped immediately (asynchronously) and is not reissued.
  - Grants are gated low while `rst` is high.
- Simultaneous `force_dbg` and `dbg_req` deassertion: no forced grant, fetch is served, and the counter clears.
- Counter at saturation with `dbg_req` low: cleared on the next edge, with no spurious debug grant.
- No address wrap handling is needed; addresses are passed through unchanged.

## Configuration
- Macro: `IMEM_ARB_STARVE_EN`.
- Defined: starvation counter and `force_dbg` are active as described above.
- Undefined:
  - Strict fetch priority; debug is granted only when `if_req` is low.
  - `starve_cnt` is not instantiated and `force_dbg` is tied to 0.
  - All other behaviour is identical.

## Test plan
Stimulus uses the program `imem` image: addr 0 = 0x00000533, addr 1 = 0x00250513, addr 2 = 0x40a505b3.

- Reset release, no requests, 3 cycles → all outputs 0, `mem_addr` = 0, no grants.
- `if_req` = 1, `if_addr` = 1 for one cycle → `if_gnt` = 1 that cycle. Next cycle: `if_rvalid` = 1 and `if_rdata` = 0x00250513. The cycle after: `if_rvalid` = 0 and `if_rdata` still holds 0x00250513.
- `dbg_req` only, `dbg_addr` = 2 → `dbg_gnt` = 1. Next cycle: `dbg_rvalid` = 1 and `dbg_rdata` = 0x40a505b3. `if_rdata` is unchanged.
- Both requesting continuously, `STARVE_MAX` = 4, macro defined:
  - Fetch is granted in cycles 0–3 and debug in cycle 4; the pattern then repeats every 5 cycles.
  - With the macro undefined, debug is never granted.
- Fetch granted at addr 0, `rst` pulsed high before the next edge → `if_rvalid` stays 0 and `if_rdata` = 0.
- Counter at 4 and `dbg_req` dropped in the same cycle → fetch granted, `dbg_gnt` = 0, counter 0 on the next edge.
